vga_target_overlay: RTL

- Parametrised multi-target successor of the single-circle pixel colouriser in the VGA path.
- Draws up to N_TGT ring markers and sprite markers over the static grid.
- Takes the grid hit, sprite ROM data and frame-buffer RAM data as inputs; produces the registered RGB pixel.
- Target positions are double-buffered and take effect only at frame boundaries; the pixel path is a fixed 3-stage pipeline.

---
 rtl/vga_target_overlay.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_target_overlay.sv
// vga_target_overlay: multi-target ring/sprite overlay for the VGA pixel path.
// Draws up to N_TGT ring markers and sprite markers over a grid/background.
// Target parameters are written into a pending bank. The active bank copies
// the pending bank on each frame pulse.
// Ports:
//   iVGA_CLK, iRST                   pixel clock, synchronous active-high reset
//   iVGA_X/Y, iFrame_Start, iMode    pixel position, frame pulse, display mode
//   iGrid, iRAM_Data                 grid hit (same cycle as X/Y), frame-buffer data (X/Y + 2)
//   oSpr_Addr / iSpr_Q               sprite ROM address (registered) / data (1-cycle latency)
//   iTgt_* / oTgt_Ready              target write port
//   oRed/oGreen/oBlue                registered pixel, X/Y + 3 cycles
module vga_target_overlay #(
    parameter int unsigned COLOR_W    = 4,
    parameter int unsigned N_TGT      = 4,
    parameter int unsigned RADIUS     = 150,
    parameter int unsigned LINE_W     = 3,
    parameter int unsigned SPR_W      = 30,
    parameter int unsigned SPR_H      = 30,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic                   iVGA_CLK,
    input  logic                   iRST,
    input  logic [9:0]             iVGA_X,
    input  logic [8:0]             iVGA_Y,
    input  logic                   iFrame_Start,
    input  logic [1:0]             iMode,
    input  logic                   iGrid,
    input  logic [3*COLOR_W-1:0]   iRAM_Data,
    output logic [9:0]             oSpr_Addr,
    input  logic [3*COLOR_W-1:0]   iSpr_Q,
    input  logic                   iTgt_Wr,
    input  logic [2:0]             iTgt_Idx,
    input  logic [9:0]             iTgt_X,
    input  logic [8:0]             iTgt_Y,
    input  logic [3*COLOR_W-1:0]   iTgt_Color,
    input  logic [1:0]             iTgt_Ctrl,
    output logic                   oTgt_Ready,
    output logic [COLOR_W-1:0]     oRed,
    output logic [COLOR_W-1:0]     oGreen,
    output logic [COLOR_W-1:0]     oBlue
);

    localparam int unsigned CW    = 3 * COLOR_W;
    localparam int unsigned H_RES = 640;
    localparam int unsigned V_RES = 480;
    localparam logic signed [10:0] HALF_W = 11'(SPR_W / 2);
    localparam logic signed [10:0] HALF_H = 11'(SPR_H / 2);
    localparam logic [20:0] RIN2  = 21'((RADIUS - LINE_W) * (RADIUS - LINE_W));
    localparam logic [20:0] ROUT2 = 21'((RADIUS + LINE_W) * (RADIUS + LINE_W));
    localparam logic [COLOR_W-1:0] CMAX = '1;
    localparam logic [1:0] M_BARS  = 2'd0;
    localparam logic [1:0] M_WHITE = 2'd1;
    localparam logic [1:0] M_RAM   = 2'd2;

    // Saturating channel add: min(q + 2*t, max)
    function automatic logic [COLOR_W-1:0] sat_add(input logic [COLOR_W-1:0] q,
                                                   input logic [COLOR_W-1:0] t);
        logic [COLOR_W+1:0] s;
        s = (COLOR_W+2)'(q) + {1'b0, t, 1'b0};
        return (s > (COLOR_W+2)'(CMAX)) ? CMAX : s[COLOR_W-1:0];
    endfunction

    // ---------------- target banks ----------------
    logic [9:0]    pend_x_q [N_TGT];
    logic [9:0]    pend_x_d [N_TGT];
    logic [8:0]    pend_y_q [N_TGT];
    logic [8:0]    pend_y_d [N_TGT];
    logic [CW-1:0] pend_c_q [N_TGT];
    logic [CW-1:0] pend_c_d [N_TGT];
    logic [1:0]    pend_k_q [N_TGT];
    logic [1:0]    pend_k_d [N_TGT];
    logic [9:0]    act_x_q  [N_TGT];
    logic [9:0]    act_x_d  [N_TGT];
    logic [8:0]    act_y_q  [N_TGT];
    logic [8:0]    act_y_d  [N_TGT];
    logic [CW-1:0] act_c_q  [N_TGT];
    logic [CW-1:0] act_c_d  [N_TGT];
    logic [1:0]    act_k_q  [N_TGT];
    logic [1:0]    act_k_d  [N_TGT];
    logic [BLINK_LOG2-1:0] frame_cnt_q, frame_cnt_d;
    logic tgt_ready_c, wr_ok_c;

    // Bank update: the swap uses the pre-write pending contents; writes are blocked on the frame cycle
    always_comb begin
        tgt_ready_c = ~iFrame_Start;
        wr_ok_c     = iTgt_Wr & tgt_ready_c & ({1'b0, iTgt_Idx} < 4'(N_TGT));
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        pend_c_d = pend_c_q;
        pend_k_d = pend_k_q;
        act_x_d  = act_x_q;
        act_y_d  = act_y_q;
        act_c_d  = act_c_q;
        act_k_d  = act_k_q;
        frame_cnt_d = frame_cnt_q;
        if (iFrame_Start) begin
            act_x_d = pend_x_q;
            act_y_d = pend_y_q;
            act_c_d = pend_c_q;
            act_k_d = pend_k_q;
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        for (int i = 0; i < int'(N_TGT); i++) begin
            if (wr_ok_c && (iTgt_Idx == 3'(i))) begin
                pend_x_d[i] = iTgt_X;
                pend_y_d[i] = iTgt_Y;
                pend_c_d[i] = iTgt_Color;
                pend_k_d[i] = iTgt_Ctrl;
            end
        end
    end

    // ---------------- S1: offsets and sprite box ----------------
    logic signed [10:0] dx_c [N_TGT];
    logic signed [10:0] dy_c [N_TGT];
    logic signed [10:0] dx_q [N_TGT];
    logic signed [10:0] dy_q [N_TGT];
    logic signed [10:0] sel_dx_c, sel_dy_c;
    logic [N_TGT-1:0] vis_c, vis_q;
    logic       spr_hit_c, spr_hit_q;
    logic [2:0] spr_idx_c, spr_idx_q;
    logic [9:0] spr_addr_c, spr_addr_q;
    logic       grid1_q, v1_q;
    logic [1:0] mode1_q;
    logic [9:0] x1_q;
    logic [8:0] y1_q;

    always_comb begin
        spr_hit_c = 1'b0;
        spr_idx_c = '0;
        sel_dx_c  = '0;
        sel_dy_c  = '0;
        vis_c     = '0;
        for (int i = 0; i < int'(N_TGT); i++) begin
            dx_c[i] = $signed({1'b0, iVGA_X}) - $signed({1'b0, act_x_q[i]});
            dy_c[i] = $signed({2'b0, iVGA_Y}) - $signed({2'b0, act_y_q[i]});
            // blinking targets hide during the upper half of the frame-counter period
            vis_c[i] = act_k_q[i][0] & ~(act_k_q[i][1] & frame_cnt_q[BLINK_LOG2-1]);
        end
        // descending scan so the lowest-index hit wins
        for (int i = int'(N_TGT) - 1; i >= 0; i--) begin
            if (vis_c[i] && (dx_c[i] >= -HALF_W) && (dx_c[i] < HALF_W) &&
                (dy_c[i] >= -HALF_H) && (dy_c[i] < HALF_H)) begin
                spr_hit_c = 1'b1;
                spr_idx_c = 3'(i);
                sel_dx_c  = dx_c[i];
                sel_dy_c  = dy_c[i];
            end
        end
        spr_addr_c = spr_hit_c ?
            10'(10'(sel_dy_c + HALF_H) * 10'(SPR_W) + 10'(sel_dx_c + HALF_W)) : '1;
    end

    // ---------------- S2: ring distance ----------------
    logic [20:0]       d2_c [N_TGT];
    logic signed [20:0] sx_c, sy_c;
    logic          ring_hit_c, ring_hit2_q;
    logic [CW-1:0] ring_col_c, ring_col2_q;
    logic [CW-1:0] spr_col_c, spr_col2_q;
    logic          spr_hit2_q, grid2_q, v2_q;
    logic [1:0]    mode2_q;
    logic [9:0]    x2_q;
    logic [8:0]    y2_q;

    always_comb begin
        ring_hit_c = 1'b0;
        ring_col_c = '0;
        spr_col_c  = '0;
        sx_c = '0;
        sy_c = '0;
        for (int i = 0; i < int'(N_TGT); i++) begin
            sx_c = 21'(dx_q[i]);
            sy_c = 21'(dy_q[i]);
            // true sum stays below 2^21, so the unsigned bit pattern is exact
            d2_c[i] = unsigned'(sx_c * sx_c) + unsigned'(sy_c * sy_c);
            if (spr_idx_q == 3'(i)) spr_col_c = act_c_q[i];
        end
        for (int i = int'(N_TGT) - 1; i >= 0; i--) begin
            if (vis_q[i] && (d2_c[i] >= RIN2) && (d2_c[i] <= ROUT2)) begin
                ring_hit_c = 1'b1;
                ring_col_c = act_c_q[i];
            end
        end
    end

    // ---------------- S3: colour selection ----------------
    logic [CW-1:0] rgb_d, rgb_q, bars_c, bg_c, spr_rgb_c;
    logic [1:0] r_idx_c;
    logic [2:0] g_idx_c, b_idx_c;

    always_comb begin
        r_idx_c = (y2_q >= 9'(3 * V_RES / 4)) ? 2'd3 : 2'(y2_q / 9'(V_RES / 4));
        g_idx_c = (x2_q >= 10'(7 * H_RES / 8)) ? 3'd7 : 3'(x2_q / 10'(H_RES / 8));
        b_idx_c = (y2_q >= 9'(7 * V_RES / 8)) ? 3'd7 : 3'(y2_q / 9'(V_RES / 8));
        bars_c  = {COLOR_W'({r_idx_c, 2'b11}), COLOR_W'({g_idx_c, 1'b1}),
                   COLOR_W'({~b_idx_c, 1'b1})};
        bg_c    = (mode2_q == M_WHITE) ? '1 : iRAM_Data;
        // tint is the target colour rotated to {B,R,G}
        spr_rgb_c = {sat_add(iSpr_Q[CW-1 -: COLOR_W],        spr_col2_q[COLOR_W-1 -: COLOR_W]),
                     sat_add(iSpr_Q[2*COLOR_W-1 -: COLOR_W], spr_col2_q[CW-1 -: COLOR_W]),
                     sat_add(iSpr_Q[COLOR_W-1 -: COLOR_W],   spr_col2_q[2*COLOR_W-1 -: COLOR_W])};
        rgb_d = '0;
        if (v2_q) begin
            if (mode2_q == M_BARS)                     rgb_d = bars_c;
            else if (mode2_q == M_RAM)                 rgb_d = iRAM_Data;
            else if (grid2_q)                          rgb_d = '0;
            else if (spr_hit2_q && (iSpr_Q != '0))     rgb_d = spr_rgb_c;
            else if (ring_hit2_q)                      rgb_d = ring_col2_q;
            else                                       rgb_d = bg_c;
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge iVGA_CLK) begin
        if (iRST) begin
            for (int i = 0; i < int'(N_TGT); i++) begin
                pend_x_q[i] <= '0;
                pend_y_q[i] <= '0;
                pend_c_q[i] <= '0;
                pend_k_q[i] <= '0;
                act_x_q[i]  <= '0;
                act_y_q[i]  <= '0;
                act_c_q[i]  <= '0;
                act_k_q[i]  <= '0;
                dx_q[i]     <= '0;
                dy_q[i]     <= '0;
            end
            frame_cnt_q <= '0;
            vis_q       <= '0;
            spr_hit_q   <= 1'b0;
            spr_idx_q   <= '0;
            spr_addr_q  <= '1;
            grid1_q     <= 1'b0;
            mode1_q     <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            v1_q        <= 1'b0;
            ring_hit2_q <= 1'b0;
            ring_col2_q <= '0;
            spr_hit2_q  <= 1'b0;
            spr_col2_q  <= '0;
            grid2_q     <= 1'b0;
            mode2_q     <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            v2_q        <= 1'b0;
            rgb_q       <= '0;
        end else begin
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
            pend_c_q <= pend_c_d;
            pend_k_q <= pend_k_d;
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
            act_c_q  <= act_c_d;
            act_k_q  <= act_k_d;
            dx_q     <= dx_c;
            dy_q     <= dy_c;
            frame_cnt_q <= frame_cnt_d;
            vis_q       <= vis_c;
            spr_hit_q   <= spr_hit_c;
            spr_idx_q   <= spr_idx_c;
            spr_addr_q  <= spr_addr_c;
            grid1_q     <= iGrid;
            mode1_q     <= iMode;
            x1_q        <= iVGA_X;
            y1_q        <= iVGA_Y;
            v1_q        <= 1'b1;
            ring_hit2_q <= ring_hit_c;
            ring_col2_q <= ring_col_c;
            spr_hit2_q  <= spr_hit_q;
            spr_col2_q  <= spr_col_c;
            grid2_q     <= grid1_q;
            mode2_q     <= mode1_q;
            x2_q        <= x1_q;
            y2_q        <= y1_q;
            v2_q        <= v1_q;
            rgb_q       <= rgb_d;
        end
    end

    assign oSpr_Addr  = spr_addr_q;
    assign oTgt_Ready = tgt_ready_c;
    assign oRed       = rgb_q[CW-1 -: COLOR_W];
    assign oGreen     = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign oBlue      = rgb_q[COLOR_W-1 -: COLOR_W];

endmodule
